// File: rtl/ysyx_22050710_sram_arbiter.sv
// Two-master SRAM-handshake arbiter: shares one memory port between instruction fetch (I) and data (D).
// One outstanding transaction; D has priority, bounded by a starvation counter that forces an I grant.
module ysyx_22050710_sram_arbiter #(
  parameter int SRAM_ADDR_WD = 32,
  parameter int SRAM_DATA_WD = 64,
  parameter int STARVE_MAX   = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_inst_req,
  input  logic [SRAM_ADDR_WD-1:0]   i_inst_addr,
  output logic                      o_inst_addr_ok,
  output logic                      o_inst_data_ok,
  output logic [SRAM_DATA_WD-1:0]   o_inst_rdata,
  input  logic                      i_data_req,
  input  logic                      i_data_wr,
  input  logic [SRAM_ADDR_WD-1:0]   i_data_addr,
  input  logic [SRAM_DATA_WD/8-1:0] i_data_wstrb,
  input  logic [SRAM_DATA_WD-1:0]   i_data_wdata,
  output logic                      o_data_addr_ok,
  output logic                      o_data_data_ok,
  output logic [SRAM_DATA_WD-1:0]   o_data_rdata,
  output logic                      o_mem_req,
  output logic                      o_mem_wr,
  output logic [SRAM_ADDR_WD-1:0]   o_mem_addr,
  output logic [SRAM_DATA_WD/8-1:0] o_mem_wstrb,
  output logic [SRAM_DATA_WD-1:0]   o_mem_wdata,
  input  logic                      i_mem_addr_ok,
  input  logic                      i_mem_data_ok,
  input  logic [SRAM_DATA_WD-1:0]   i_mem_rdata
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ADDR = 2'd1,
    WAIT_DATA = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state;
  state_t     state_nxt;
  logic       owner;
  logic       owner_nxt;
  logic [3:0] starve_cnt;
  logic [3:0] starve_nxt;
  logic       grant_d;
  logic       sel_d;
  logic       sel_vld;
  logic       hs;
  logic       rsp;
  logic       live;
  logic       issue;

  // State, owner and starvation counter registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      starve_cnt <= 4'd0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Grant selection, next-state and starvation counter update
  always_comb begin
    grant_d    = i_data_req && !(i_inst_req && (starve_cnt == STARVE_LIM));
    sel_d      = 1'b0;
    sel_vld    = 1'b0;
    rsp        = 1'b0;
    state_nxt  = state;
    owner_nxt  = owner;
    starve_nxt = starve_cnt;

    // In IDLE a losing D implies a pending I, so any request yields a valid selection
    case (state)
      IDLE: begin
        sel_d   = grant_d;
        sel_vld = i_data_req || i_inst_req;
      end
      WAIT_ADDR: begin
        sel_d   = owner;
        sel_vld = owner ? i_data_req : i_inst_req;
      end
      WAIT_DATA: begin
        rsp = i_mem_data_ok;
      end
      default: begin
        sel_d = 1'b0;
      end
    endcase

    hs = sel_vld && i_mem_addr_ok;

    case (state)
      IDLE: begin
        if (hs) begin
          state_nxt = WAIT_DATA;
          owner_nxt = sel_d;
        end else if (sel_vld) begin
          state_nxt = WAIT_ADDR;
          owner_nxt = sel_d;
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT_ADDR: begin
        if (hs) begin
          state_nxt = WAIT_DATA;
        end else if (!sel_vld) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = WAIT_ADDR;
        end
      end
      WAIT_DATA: begin
        if (rsp) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = WAIT_DATA;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (hs) begin
      if (sel_d && i_inst_req) begin
        starve_nxt = (starve_cnt == STARVE_LIM) ? STARVE_LIM : 4'(starve_cnt + 4'd1);
      end else begin
        starve_nxt = 4'd0;
      end
    end else begin
      starve_nxt = starve_cnt;
    end
  end

  // Outputs are forced low while reset is held, whatever the inputs do
  assign live  = !i_rst;
  assign issue = live && sel_vld;

  assign o_mem_req   = issue;
  assign o_mem_wr    = issue && sel_d && i_data_wr;
  assign o_mem_addr  = issue ? (sel_d ? i_data_addr : i_inst_addr) : '0;
  assign o_mem_wstrb = (issue && sel_d) ? i_data_wstrb : '0;
  assign o_mem_wdata = (issue && sel_d) ? i_data_wdata : '0;

  assign o_inst_addr_ok = live && hs && !sel_d;
  assign o_data_addr_ok = live && hs && sel_d;

  assign o_inst_data_ok = live && rsp && !owner;
  assign o_data_data_ok = live && rsp && owner;
  assign o_inst_rdata   = o_inst_data_ok ? i_mem_rdata : '0;
  assign o_data_rdata   = o_data_data_ok ? i_mem_rdata : '0;

endmodule

// File: tb/tb_ysyx_22050710_sram_arbiter.sv
// Scoreboard bench for the SRAM arbiter: directed scenarios, then randomized masters
// against a memory model; responses are checked by an independent monitor process.
module tb_ysyx_22050710_sram_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 64;
  localparam int SW   = DW / 8;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_inst_req;
  logic [AW-1:0] i_inst_addr;
  logic          o_inst_addr_ok, o_inst_data_ok;
  logic [DW-1:0] o_inst_rdata;
  logic          i_data_req, i_data_wr;
  logic [AW-1:0] i_data_addr;
  logic [SW-1:0] i_data_wstrb;
  logic [DW-1:0] i_data_wdata;
  logic          o_data_addr_ok, o_data_data_ok;
  logic [DW-1:0] o_data_rdata;
  logic          o_mem_req, o_mem_wr;
  logic [AW-1:0] o_mem_addr;
  logic [SW-1:0] o_mem_wstrb;
  logic [DW-1:0] o_mem_wdata;
  logic          i_mem_addr_ok, i_mem_data_ok;
  logic [DW-1:0] i_mem_rdata;
  logic          any_out;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] iq[$];
  logic [DW-1:0] dq[$];

  // random-phase model state
  logic          ireq, dreq, dwr, busy, pend;
  logic [AW-1:0] iaddr, daddr;
  logic [SW-1:0] dstrb;
  logic [DW-1:0] dwdata, resp, pv;
  int            lat, cnt_m, k;

  always #5 clk = ~clk;

  ysyx_22050710_sram_arbiter #(.SRAM_ADDR_WD(AW), .SRAM_DATA_WD(DW), .STARVE_MAX(SMAX)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_inst_req(i_inst_req), .i_inst_addr(i_inst_addr),
    .o_inst_addr_ok(o_inst_addr_ok), .o_inst_data_ok(o_inst_data_ok), .o_inst_rdata(o_inst_rdata),
    .i_data_req(i_data_req), .i_data_wr(i_data_wr), .i_data_addr(i_data_addr),
    .i_data_wstrb(i_data_wstrb), .i_data_wdata(i_data_wdata),
    .o_data_addr_ok(o_data_addr_ok), .o_data_data_ok(o_data_data_ok), .o_data_rdata(o_data_rdata),
    .o_mem_req(o_mem_req), .o_mem_wr(o_mem_wr), .o_mem_addr(o_mem_addr),
    .o_mem_wstrb(o_mem_wstrb), .o_mem_wdata(o_mem_wdata),
    .i_mem_addr_ok(i_mem_addr_ok), .i_mem_data_ok(i_mem_data_ok), .i_mem_rdata(i_mem_rdata)
  );

  assign any_out = |{o_inst_addr_ok, o_inst_data_ok, o_inst_rdata, o_data_addr_ok, o_data_data_ok,
                     o_data_rdata, o_mem_req, o_mem_wr, o_mem_addr, o_mem_wstrb, o_mem_wdata};

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory content: a fixed function of the address
  function automatic logic [DW-1:0] f(input logic [AW-1:0] a);
    return {a ^ 32'hA5A5_5A5A, ~a};
  endfunction

  task automatic idle_inputs();
    i_inst_req = 1'b0; i_inst_addr = 32'd0;
    i_data_req = 1'b0; i_data_wr = 1'b0; i_data_addr = 32'd0;
    i_data_wstrb = 8'd0; i_data_wdata = 64'd0;
    i_mem_addr_ok = 1'b0; i_mem_data_ok = 1'b0; i_mem_rdata = 64'd0;
  endtask

  // monitor: every response must match the oldest expectation of its master
  always @(negedge clk) begin
    #2;
    if (!i_rst) begin
      if (o_inst_data_ok) begin
        if (iq.size() == 0) chk("inst_unexpected_data_ok", 64'd1, 64'd0);
        else chk("inst_rdata", o_inst_rdata, iq.pop_front());
      end else begin
        chk("inst_rdata_zero", o_inst_rdata, 64'd0);
      end
      if (o_data_data_ok) begin
        if (dq.size() == 0) chk("data_unexpected_data_ok", 64'd1, 64'd0);
        else chk("data_rdata", o_data_rdata, dq.pop_front());
      end else begin
        chk("data_rdata_zero", o_data_rdata, 64'd0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    // reset with both masters and the memory active
    idle_inputs();
    i_rst = 1'b1; i_inst_req = 1'b1; i_data_req = 1'b1; i_data_wr = 1'b1;
    i_inst_addr = 32'h8000_0000; i_data_addr = 32'h8000_1000;
    i_mem_addr_ok = 1'b1; i_mem_data_ok = 1'b1; i_mem_rdata = '1;
    repeat (2) @(negedge clk);
    #1 chk("reset_outputs", 64'(any_out), 64'd0);

    // I-only read, zero-cycle accept, data 3 cycles later
    @(negedge clk); i_rst = 1'b0; idle_inputs();
    @(negedge clk); i_inst_req = 1'b1; i_inst_addr = 32'h8000_0000; i_mem_addr_ok = 1'b1;
    #1 chk("t1_inst_addr_ok", 64'(o_inst_addr_ok), 64'd1);
    chk("t1_mem_addr", 64'(o_mem_addr), 64'h8000_0000);
    chk("t1_data_addr_ok", 64'(o_data_addr_ok), 64'd0);
    iq.push_back(64'h1122_3344_5566_7788);
    @(negedge clk); idle_inputs();
    @(negedge clk);
    @(negedge clk); i_mem_data_ok = 1'b1; i_mem_rdata = 64'h1122_3344_5566_7788;
    #1 chk("t1_inst_data_ok", 64'(o_inst_data_ok), 64'd1);
    chk("t1_inst_rdata", o_inst_rdata, 64'h1122_3344_5566_7788);
    chk("t1_data_data_ok", 64'(o_data_data_ok), 64'd0);

    // simultaneous requests: D write wins, I only after D's data_ok
    @(negedge clk); idle_inputs();
    i_inst_req = 1'b1; i_inst_addr = 32'h8000_2000;
    i_data_req = 1'b1; i_data_wr = 1'b1; i_data_addr = 32'h8000_1000;
    i_data_wstrb = 8'hFF; i_data_wdata = 64'hDEAD_BEEF_0123_4567; i_mem_addr_ok = 1'b1;
    #1 chk("t2_mem_wr", 64'(o_mem_wr), 64'd1);
    chk("t2_mem_addr", 64'(o_mem_addr), 64'h8000_1000);
    chk("t2_mem_wstrb", 64'(o_mem_wstrb), 64'hFF);
    chk("t2_mem_wdata", o_mem_wdata, 64'hDEAD_BEEF_0123_4567);
    chk("t2_data_addr_ok", 64'(o_data_addr_ok), 64'd1);
    chk("t2_inst_addr_ok", 64'(o_inst_addr_ok), 64'd0);
    dq.push_back(64'h0000_0000_0000_5A5A);
    @(negedge clk); i_data_req = 1'b0;
    #1 chk("t2_wait_mem_req", 64'(o_mem_req), 64'd0);
    chk("t2_wait_inst_addr_ok", 64'(o_inst_addr_ok), 64'd0);
    @(negedge clk); i_mem_data_ok = 1'b1; i_mem_rdata = 64'h0000_0000_0000_5A5A;
    #1 chk("t2_data_data_ok", 64'(o_data_data_ok), 64'd1);
    chk("t2_inst_addr_ok_resp", 64'(o_inst_addr_ok), 64'd0);
    @(negedge clk); i_mem_data_ok = 1'b0;
    #1 chk("t2_inst_granted", 64'(o_inst_addr_ok), 64'd1);
    chk("t2_inst_mem_addr", 64'(o_mem_addr), 64'h8000_2000);
    iq.push_back(f(32'h8000_2000));
    @(negedge clk); i_inst_req = 1'b0; i_mem_addr_ok = 1'b0; i_mem_data_ok = 1'b1;
    i_mem_rdata = f(32'h8000_2000);
    @(negedge clk); idle_inputs();

    // starvation: both always requesting, memory always ready
    i_inst_req = 1'b1; i_inst_addr = 32'h8000_3000;
    i_data_req = 1'b1; i_data_addr = 32'h8000_4000; i_mem_addr_ok = 1'b1;
    k = 0; pend = 1'b0; pv = 64'd0;
    for (int c = 0; c < 40 && k < 10; c++) begin
      i_mem_data_ok = pend; i_mem_rdata = pv;
      #1;
      if (i_mem_data_ok) begin
        pend = 1'b0;
      end else if (o_data_addr_ok || o_inst_addr_ok) begin
        chk($sformatf("t3_grant%0d_is_d", k), 64'(o_data_addr_ok), (k % (SMAX + 1) == SMAX) ? 64'd0 : 64'd1);
        pv = 64'hC0DE_0000_0000_0000 + 64'(k);
        if (o_data_addr_ok) dq.push_back(pv); else iq.push_back(pv);
        pend = 1'b1;
        k++;
      end
      @(negedge clk);
    end
    chk("t3_grants_seen", 64'(k), 64'd10);
    idle_inputs(); i_mem_data_ok = pend; i_mem_rdata = pv;
    @(negedge clk); idle_inputs();

    // backpressure: D owns the port for 5 cycles while I waits
    i_data_req = 1'b1; i_data_addr = 32'h8000_5000;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin i_inst_req = 1'b1; i_inst_addr = 32'h8000_6000; end
      #1 chk($sformatf("t4_mem_addr%0d", c), 64'(o_mem_addr), 64'h8000_5000);
      chk($sformatf("t4_inst_addr_ok%0d", c), 64'(o_inst_addr_ok), 64'd0);
      chk($sformatf("t4_data_addr_ok%0d", c), 64'(o_data_addr_ok), 64'd0);
      @(negedge clk);
    end
    i_mem_addr_ok = 1'b1;
    #1 chk("t4_data_accept", 64'(o_data_addr_ok), 64'd1);
    chk("t4_inst_blocked", 64'(o_inst_addr_ok), 64'd0);
    dq.push_back(f(32'h8000_5000));
    @(negedge clk); i_data_req = 1'b0;
    #1 chk("t4_wait_inst_blocked", 64'(o_inst_addr_ok), 64'd0);
    @(negedge clk); i_mem_data_ok = 1'b1; i_mem_rdata = f(32'h8000_5000);
    #1 chk("t4_resp_inst_blocked", 64'(o_inst_addr_ok), 64'd0);
    @(negedge clk); i_mem_data_ok = 1'b0;
    #1 chk("t4_inst_accept", 64'(o_inst_addr_ok), 64'd1);
    iq.push_back(f(32'h8000_6000));
    @(negedge clk); i_inst_req = 1'b0; i_mem_addr_ok = 1'b0; i_mem_data_ok = 1'b1;
    i_mem_rdata = f(32'h8000_6000);
    @(negedge clk); idle_inputs();

    // flush in WAIT_ADDR, then stray responses in IDLE and WAIT_ADDR
    @(negedge clk); i_data_req = 1'b1; i_data_addr = 32'h8000_7000;
    #1 chk("t5_d_issued", 64'(o_mem_req), 64'd1);
    @(negedge clk); i_data_req = 1'b0; i_inst_req = 1'b1; i_inst_addr = 32'h8000_8000; i_mem_addr_ok = 1'b1;
    #1 chk("t5_flush_no_d_ok", 64'(o_data_addr_ok), 64'd0);
    chk("t5_locked_no_i_ok", 64'(o_inst_addr_ok), 64'd0);
    chk("t5_flush_mem_req", 64'(o_mem_req), 64'd0);
    @(negedge clk); i_mem_addr_ok = 1'b0;
    #1 chk("t5_idle_after_flush", 64'(o_mem_addr), 64'h8000_8000);
    @(negedge clk); i_inst_req = 1'b0;
    #1 chk("t5_i_flush", 64'(o_mem_req), 64'd0);
    @(negedge clk); i_mem_data_ok = 1'b1; i_mem_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
    #1 chk("t5_stray_idle", 64'({o_inst_data_ok, o_data_data_ok}), 64'd0);
    @(negedge clk); i_inst_req = 1'b1; i_inst_addr = 32'h8000_8800;
    #1 chk("t5_stray_waddr", 64'({o_inst_data_ok, o_data_data_ok}), 64'd0);
    @(negedge clk); i_mem_addr_ok = 1'b1;
    #1 chk("t5_accept_with_stray", 64'(o_inst_addr_ok), 64'd1);
    iq.push_back(f(32'h8000_8800));
    @(negedge clk); idle_inputs();
    #1 chk("t5_no_early_data", 64'(o_inst_data_ok), 64'd0);
    @(negedge clk); i_mem_data_ok = 1'b1; i_mem_rdata = f(32'h8000_8800);
    @(negedge clk); idle_inputs();

    // asynchronous reset while waiting for data
    i_data_req = 1'b1; i_data_addr = 32'h8000_9000; i_mem_addr_ok = 1'b1;
    #1 chk("t6_d_accept", 64'(o_data_addr_ok), 64'd1);
    @(negedge clk); idle_inputs();
    @(negedge clk); i_rst = 1'b1; i_inst_req = 1'b1; i_mem_addr_ok = 1'b1; i_mem_data_ok = 1'b1;
    i_mem_rdata = 64'h7777_7777_7777_7777;
    #1 chk("t6_reset_outputs", 64'(any_out), 64'd0);
    idle_inputs();
    #1 i_rst = 1'b0;
    @(negedge clk); i_mem_data_ok = 1'b1; i_mem_rdata = 64'h6666_6666_6666_6666;
    #1 chk("t6_late_resp_ignored", 64'({o_inst_data_ok, o_data_data_ok}), 64'd0);
    @(negedge clk); idle_inputs(); i_inst_req = 1'b1; i_inst_addr = 32'h8000_A000; i_mem_addr_ok = 1'b1;
    #1 chk("t6_idle_after_reset", 64'(o_inst_addr_ok), 64'd1);
    iq.push_back(f(32'h8000_A000));
    @(negedge clk); idle_inputs(); i_mem_data_ok = 1'b1; i_mem_rdata = f(32'h8000_A000);

    // randomized traffic against the memory model
    busy = 1'b0; lat = 0; cnt_m = 0; ireq = 1'b0; dreq = 1'b0; resp = 64'd0;
    iaddr = 32'd0; daddr = 32'd0; dwr = 1'b0; dstrb = 8'd0; dwdata = 64'd0;
    for (int c = 0; c < 3100; c++) begin
      @(negedge clk);
      if (busy && lat == 0) begin
        i_mem_data_ok = 1'b1; i_mem_rdata = resp;
      end else if (!busy && $urandom_range(0, 7) == 0) begin
        i_mem_data_ok = 1'b1; i_mem_rdata = {$urandom, $urandom};
      end else begin
        i_mem_data_ok = 1'b0; i_mem_rdata = {$urandom, $urandom};
      end
      i_mem_addr_ok = 1'($urandom_range(0, 1));
      if (c < 3000) begin
        if (!ireq && $urandom_range(0, 2) == 0) begin
          ireq = 1'b1; iaddr = $urandom & 32'hFFFF_FFF8;
        end
        if (!dreq) begin
          if ($urandom_range(0, 1) == 0) begin
            dreq = 1'b1; dwr = 1'($urandom_range(0, 1)); daddr = $urandom & 32'hFFFF_FFF8;
            dstrb = 8'($urandom); dwdata = {$urandom, $urandom};
          end
        end else if ($urandom_range(0, 15) == 0) begin
          dreq = 1'b0;
        end
      end else begin
        ireq = 1'b0; dreq = 1'b0;
      end
      i_inst_req = ireq; i_inst_addr = iaddr;
      i_data_req = dreq; i_data_wr = dwr; i_data_addr = daddr; i_data_wstrb = dstrb; i_data_wdata = dwdata;
      #1;
      if (busy) chk("r_one_outstanding", 64'(o_mem_req), 64'd0);
      if (o_mem_req && i_mem_addr_ok) chk("r_one_addr_ok", 64'(o_inst_addr_ok) + 64'(o_data_addr_ok), 64'd1);
      else chk("r_no_addr_ok", 64'(o_inst_addr_ok | o_data_addr_ok), 64'd0);
      if (o_data_addr_ok) begin
        chk("r_d_addr", 64'(o_mem_addr), 64'(daddr));
        chk("r_d_wr_strb", 64'({o_mem_wr, o_mem_wstrb}), 64'({dwr, dwr ? dstrb : 8'd0}) | 64'({1'b0, dstrb}));
        chk("r_d_wdata", o_mem_wdata, dwdata);
        if (ireq) begin
          chk("r_starve_bound", 64'(cnt_m < SMAX), 64'd1);
          if (cnt_m < SMAX) cnt_m++;
        end else begin
          cnt_m = 0;
        end
        resp = f(daddr); dq.push_back(resp);
        busy = 1'b1; lat = $urandom_range(0, 3); dreq = 1'b0;
      end else if (o_inst_addr_ok) begin
        chk("r_i_addr", 64'(o_mem_addr), 64'(iaddr));
        chk("r_i_rd", 64'(o_mem_wr), 64'd0);
        cnt_m = 0;
        resp = f(iaddr); iq.push_back(resp);
        busy = 1'b1; lat = $urandom_range(0, 3); ireq = 1'b0;
      end else if (busy) begin
        if (lat == 0) busy = 1'b0;
        else lat--;
      end
    end
    @(negedge clk); idle_inputs();
    #3 chk("queues_drained", 64'(iq.size() + dq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
